// File: rtl/av2_obu_pkg.sv
// Shared definitions for the AV2 OBU front-end parser: OBU types, header
// bit positions, FSM encoding and byte-mask helpers.
package av2_obu_pkg;

   localparam logic [3:0] OBU_RESERVED0 = 4'd0;
   localparam logic [3:0] SEQ_HDR       = 4'd1;
   localparam logic [3:0] TD            = 4'd2;
   localparam logic [3:0] FRAME_HDR     = 4'd3;
   localparam logic [3:0] TILE_GROUP    = 4'd4;
   localparam logic [3:0] METADATA      = 4'd5;
   localparam logic [3:0] FRAME         = 4'd6;
   localparam logic [3:0] PADDING       = 4'd15;

   // Bit positions inside the header byte.
   localparam int HDR_FORBIDDEN_BIT = 7;
   localparam int HDR_TYPE_LSB      = 3;
   localparam int HDR_EXT_BIT       = 2;
   localparam int HDR_HAS_SIZE_BIT  = 1;

   typedef enum logic [1:0] {
      ST_HDR     = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_DROP_SZ = 2'd2,
      ST_DROP    = 2'd3
   } obu_state_e;

   // Keep bits for the top n bytes of a beat (keep bit15 = byte0).
   function automatic logic [15:0] keep_top(input logic [4:0] n);
      return ~(16'hFFFF >> n);
   endfunction

   function automatic logic [127:0] byte_mask(input logic [15:0] k);
      logic [127:0] m;
      m = '0;
      for (int i = 0; i < 16; i++) m[8*i +: 8] = {8{k[i]}};
      return m;
   endfunction

endpackage

// File: rtl/av2_axis_out_reg.sv
// One-deep AXI4-Stream output register: holds data and sideband stable while
// valid is stalled, and accepts a new beat every cycle when downstream is ready.
module av2_axis_out_reg
   import av2_obu_pkg::*;
#(
   parameter int DATA_BYTES = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_load,
   input  logic [8*DATA_BYTES-1:0] in_data,
   input  logic [DATA_BYTES-1:0]   in_keep,
   input  logic                    in_last,
   input  logic [3:0]              in_type,
   output logic                    in_ready,
   output logic [8*DATA_BYTES-1:0] m_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tlast,
   output logic [DATA_BYTES-1:0]   m_axis_tkeep,
   output logic [3:0]              m_obu_type
);

   logic [8*DATA_BYTES-1:0] tdata_p1;
   logic [DATA_BYTES-1:0]   tkeep_p1;
   logic                    tlast_p1;
   logic [3:0]              type_p1;
   logic                    vld_p1;

   assign in_ready = !vld_p1 || m_axis_tready;

   // Stage p1: registered output beat
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1   <= 1'b0;
         tdata_p1 <= '0;
         tkeep_p1 <= '0;
         tlast_p1 <= 1'b0;
         type_p1  <= '0;
      end else if (in_load) begin
         vld_p1   <= 1'b1;
         tdata_p1 <= in_data;
         tkeep_p1 <= in_keep;
         tlast_p1 <= in_last;
         type_p1  <= in_type;
      end else if (m_axis_tready) begin
         vld_p1   <= 1'b0;
      end
   end

   assign m_axis_tdata  = tdata_p1;
   assign m_axis_tvalid = vld_p1;
   assign m_axis_tlast  = tlast_p1;
   assign m_axis_tkeep  = tkeep_p1;
   assign m_obu_type    = type_p1;

endmodule

// File: rtl/av2_obu_parser.sv
// AV2 OBU header/size parser: forwards payload beats tagged with the OBU type,
// drops padding/reserved OBUs and flags malformed or truncated ones.
module av2_obu_parser
   import av2_obu_pkg::*;
#(
   parameter int DATA_BYTES = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [8*DATA_BYTES-1:0] s_axis_tdata,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic                    s_axis_tlast,
   input  logic [DATA_BYTES-1:0]   s_axis_tkeep,
   output logic [8*DATA_BYTES-1:0] m_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tlast,
   output logic [DATA_BYTES-1:0]   m_axis_tkeep,
   output logic [3:0]              m_obu_type,
   output logic                    hdr_valid,
   output logic [3:0]              hdr_type,
   output logic [7:0]              hdr_size,
   output logic                    err_pulse,
   output logic [CNT_WIDTH-1:0]    obu_count,
   output logic [CNT_WIDTH-1:0]    err_count
);

   localparam int DW = 8 * DATA_BYTES;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   obu_state_e state, state_nx;
   logic [7:0] rem, rem_nx, rem_sub, sz_byte;
   logic       unb, unb_nx;
   logic [4:0] take;
   logic       forbidden, has_size, ext_flag, size_done;
   logic [3:0] typ;
   logic       hdr_valid_nx, err_nx, obu_inc;
   logic [3:0] hdr_type_nx;
   logic [7:0] hdr_size_nx;
   logic       out_load, out_last, out_rdy;
   logic [15:0] out_keep;

   assign forbidden = s_axis_tdata[DW-8+HDR_FORBIDDEN_BIT];
   assign typ       = s_axis_tdata[DW-8+HDR_TYPE_LSB +: 4];
   assign ext_flag  = s_axis_tdata[DW-8+HDR_EXT_BIT];
   assign has_size  = s_axis_tdata[DW-8+HDR_HAS_SIZE_BIT];
   assign sz_byte   = ext_flag ? s_axis_tdata[DW-24 +: 8] : s_axis_tdata[DW-16 +: 8];

   // Bytes consumed by this beat; unbounded OBUs always take the full beat.
   assign take      = (unb || rem >= 8'd16) ? 5'd16 : rem[4:0];
   assign rem_sub   = rem - {3'b000, take};
   assign size_done = !unb && (rem_sub == 8'd0);
   assign out_keep  = s_axis_tkeep & keep_top(take);

   always_comb begin
      state_nx      = state;
      rem_nx        = rem;
      unb_nx        = unb;
      hdr_valid_nx  = 1'b0;
      err_nx        = 1'b0;
      obu_inc       = 1'b0;
      hdr_type_nx   = hdr_type;
      hdr_size_nx   = hdr_size;
      out_load      = 1'b0;
      out_last      = 1'b0;
      s_axis_tready = 1'b0;
      case (state)
         ST_HDR: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid) begin
               obu_inc      = 1'b1;
               hdr_valid_nx = 1'b1;
               hdr_type_nx  = typ;
               hdr_size_nx  = has_size ? sz_byte : 8'd0;
               if (forbidden) begin
                  err_nx = 1'b1;
                  if (!s_axis_tlast) state_nx = ST_DROP;
               end else if (has_size && sz_byte == 8'd0) begin
                  state_nx = ST_HDR;
               end else if (s_axis_tlast) begin
                  // An unsized OBU ending on its header is simply empty.
                  err_nx = has_size;
               end else begin
                  rem_nx   = has_size ? sz_byte : 8'd0;
                  unb_nx   = !has_size;
                  state_nx = (typ == OBU_RESERVED0 || typ == PADDING) ? ST_DROP_SZ : ST_PAYLOAD;
               end
            end
         end
         ST_PAYLOAD: begin
            s_axis_tready = out_rdy;
            if (s_axis_tvalid && out_rdy) begin
               out_load = 1'b1;
               rem_nx   = unb ? rem : rem_sub;
               out_last = size_done || s_axis_tlast;
               err_nx   = s_axis_tlast && !unb && !size_done;
               if (out_last) state_nx = ST_HDR;
            end
         end
         ST_DROP_SZ: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid) begin
               rem_nx = unb ? rem : rem_sub;
               err_nx = s_axis_tlast && !unb && !size_done;
               if (size_done || s_axis_tlast) state_nx = ST_HDR;
            end
         end
         ST_DROP: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid && s_axis_tlast) state_nx = ST_HDR;
         end
         default: state_nx = ST_HDR;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_HDR;
         rem       <= '0;
         unb       <= 1'b0;
         hdr_valid <= 1'b0;
         err_pulse <= 1'b0;
         hdr_type  <= '0;
         hdr_size  <= '0;
         obu_count <= '0;
         err_count <= '0;
      end else begin
         state     <= state_nx;
         rem       <= rem_nx;
         unb       <= unb_nx;
         hdr_valid <= hdr_valid_nx;
         err_pulse <= err_nx;
         hdr_type  <= hdr_type_nx;
         hdr_size  <= hdr_size_nx;
         if (obu_inc) obu_count <= sat_inc(obu_count);
         if (err_nx)  err_count <= sat_inc(err_count);
      end
   end

   av2_axis_out_reg #(.DATA_BYTES(DATA_BYTES)) u_out_reg (
      .clk           (clk),
      .rst           (rst),
      .in_load       (out_load),
      .in_data       (s_axis_tdata & byte_mask(keep_top(take))),
      .in_keep       (out_keep),
      .in_last       (out_last),
      .in_type       (hdr_type),
      .in_ready      (out_rdy),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_obu_type    (m_obu_type)
   );

endmodule

// File: tb/tb_av2_obu_parser.sv
// Directed, table-driven bench for av2_obu_parser with a few hand-written
// multi-beat sequences (chained headers, truncation under backpressure, reset).
module tb_av2_obu_parser;
   import av2_obu_pkg::*;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [127:0] s_axis_tdata = '0;
   logic         s_axis_tvalid = 1'b0;
   logic         s_axis_tready;
   logic         s_axis_tlast = 1'b0;
   logic [15:0]  s_axis_tkeep = '0;
   logic [127:0] m_axis_tdata;
   logic         m_axis_tvalid;
   logic         m_axis_tready = 1'b1;
   logic         m_axis_tlast;
   logic [15:0]  m_axis_tkeep;
   logic [3:0]   m_obu_type;
   logic         hdr_valid;
   logic [3:0]   hdr_type;
   logic [7:0]   hdr_size;
   logic         err_pulse;
   logic [15:0]  obu_count;
   logic [15:0]  err_count;

   av2_obu_parser #(.DATA_BYTES(16), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
      .s_axis_tkeep(s_axis_tkeep),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
      .m_axis_tkeep(m_axis_tkeep), .m_obu_type(m_obu_type),
      .hdr_valid(hdr_valid), .hdr_type(hdr_type), .hdr_size(hdr_size),
      .err_pulse(err_pulse), .obu_count(obu_count), .err_count(err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] data;
      logic [15:0]  keep;
      logic         last;
      logic [3:0]   otype;
   } beat_t;

   typedef struct {
      string        name;
      logic [127:0] hdr;
      logic         hdr_last;
      int           npay;
      int           last_idx;
      logic [15:0]  keep_last_in;
      int           exp_beats;
      logic [15:0]  exp_keep_last;
      logic [3:0]   exp_type;
      logic [7:0]   exp_size;
      int           exp_err;
   } vec_t;

   beat_t beats[$];
   int    hv_seen, ep_seen;
   int    checks = 0, errors = 0;
   int    exp_obu = 0, exp_errs = 0;
   bit    toggle_ready = 1'b0;

   // Output monitor: inputs only change 1 ns after posedge, so negedge is stable.
   always @(negedge clk) begin
      if (!rst) begin
         if (m_axis_tvalid && m_axis_tready)
            beats.push_back('{m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_obu_type});
         if (hdr_valid) hv_seen++;
         if (err_pulse) ep_seen++;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         m_axis_tready = toggle_ready ? ~m_axis_tready : 1'b1;
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] pay(input int k);
      return 128'h00112233445566778899AABBCCDDEEFF ^ {16{k[7:0]}};
   endfunction

   task automatic send(input logic [127:0] d, input logic [15:0] k, input logic l);
      bit done;
      done = 1'b0;
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      s_axis_tlast  = l;
      s_axis_tvalid = 1'b1;
      for (int c = 0; c < 50 && !done; c++) begin
         @(negedge clk);
         if (s_axis_tready) begin
            @(posedge clk);
            done = 1'b1;
         end
      end
      #1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got tready=0 for 50 cycles, required acceptance");
      end
   endtask

   task automatic drain_and_clear_start();
      repeat (8) @(posedge clk);
      #2;
   endtask

   task automatic clear_obs();
      beats.delete();
      hv_seen = 0;
      ep_seen = 0;
   endtask

   vec_t vecs[9];

   initial begin
      vecs[0] = '{"sized_16",    {8'h0A, 8'h10, 112'h0}, 1'b0, 1, -1, 16'hFFFF, 1, 16'hFFFF, 4'd1, 8'd16, 0};
      vecs[1] = '{"sized_5",     {8'h32, 8'h05, 112'h0}, 1'b0, 1, -1, 16'hFFFF, 1, 16'hF800, 4'd6, 8'd5,  0};
      vecs[2] = '{"padding",     {8'h7A, 8'h20, 112'h0}, 1'b0, 2, -1, 16'hFFFF, 0, 16'h0000, 4'd15, 8'd32, 0};
      vecs[3] = '{"forbidden",   {8'h8A, 8'h10, 112'h0}, 1'b0, 3, 2,  16'hFFFF, 0, 16'h0000, 4'd1, 8'd16, 1};
      vecs[4] = '{"ext_size",    {8'h1E, 8'hFF, 8'h03, 104'h0}, 1'b0, 1, -1, 16'hFFFF, 1, 16'hE000, 4'd3, 8'd3, 0};
      vecs[5] = '{"unbounded",   {8'h20, 8'h55, 112'h0}, 1'b0, 3, 2,  16'hFF00, 3, 16'hFF00, 4'd4, 8'd0,  0};
      vecs[6] = '{"zero_size",   {8'h0A, 8'h00, 112'h0}, 1'b0, 0, -1, 16'hFFFF, 0, 16'h0000, 4'd1, 8'd0,  0};
      vecs[7] = '{"hdr_trunc",   {8'h22, 8'h08, 112'h0}, 1'b1, 0, -1, 16'hFFFF, 0, 16'h0000, 4'd4, 8'd8,  1};
      vecs[8] = '{"dropsz_trunc",{8'h7A, 8'h40, 112'h0}, 1'b0, 2, 1,  16'hFFFF, 0, 16'h0000, 4'd15, 8'd64, 1};

      clear_obs();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_m_valid", 128'(m_axis_tvalid), 128'd0);
      chk("reset_hdr_valid", 128'(hdr_valid), 128'd0);
      chk("reset_obu_count", 128'(obu_count), 128'd0);
      chk("reset_err_count", 128'(err_count), 128'd0);
      chk("reset_hdr_type", 128'(hdr_type), 128'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int v = 0; v < 9; v++) begin
         logic [127:0] m;
         clear_obs();
         send(vecs[v].hdr, 16'hFFFF, vecs[v].hdr_last);
         for (int p = 0; p < vecs[v].npay; p++)
            send(pay(p + 16*v), (p == vecs[v].last_idx || p == vecs[v].npay - 1) ?
                 vecs[v].keep_last_in : 16'hFFFF, p == vecs[v].last_idx);
         drain_and_clear_start();
         exp_obu++;
         exp_errs += vecs[v].exp_err;
         chk({vecs[v].name, "_hdr_pulses"}, 128'(hv_seen), 128'd1);
         chk({vecs[v].name, "_hdr_type"}, 128'(hdr_type), 128'(vecs[v].exp_type));
         chk({vecs[v].name, "_hdr_size"}, 128'(hdr_size), 128'(vecs[v].exp_size));
         chk({vecs[v].name, "_beats"}, 128'(beats.size()), 128'(vecs[v].exp_beats));
         chk({vecs[v].name, "_err_pulses"}, 128'(ep_seen), 128'(vecs[v].exp_err));
         chk({vecs[v].name, "_obu_count"}, 128'(obu_count), 128'(exp_obu));
         chk({vecs[v].name, "_err_count"}, 128'(err_count), 128'(exp_errs));
         if (beats.size() == vecs[v].exp_beats && vecs[v].exp_beats > 0) begin
            for (int b = 0; b < beats.size(); b++) begin
               m = byte_mask(beats[b].keep);
               chk({vecs[v].name, "_data"}, beats[b].data & m, pay(b + 16*v) & m);
               chk({vecs[v].name, "_otype"}, 128'(beats[b].otype), 128'(vecs[v].exp_type));
               chk({vecs[v].name, "_tlast"}, 128'(beats[b].last), 128'(b == beats.size() - 1));
            end
            chk({vecs[v].name, "_keep_last"}, 128'(beats[beats.size()-1].keep), 128'(vecs[v].exp_keep_last));
         end
      end

      // Size 32 consumes two beats; the third beat is the next header.
      clear_obs();
      send({8'h1A, 8'h20, 112'h0}, 16'hFFFF, 1'b0);
      send(pay(200), 16'hFFFF, 1'b0);
      send(pay(201), 16'hFFFF, 1'b0);
      send({8'h0A, 8'h10, 112'h0}, 16'hFFFF, 1'b0);
      send(pay(202), 16'hFFFF, 1'b0);
      drain_and_clear_start();
      exp_obu += 2;
      chk("chain_beats", 128'(beats.size()), 128'd3);
      chk("chain_hdr_pulses", 128'(hv_seen), 128'd2);
      chk("chain_obu_count", 128'(obu_count), 128'(exp_obu));
      if (beats.size() == 3) begin
         chk("chain_b0", {beats[0].data, 4'(beats[0].otype), 1'(beats[0].last)} >> 5,
             {pay(200), 4'd3, 1'b0} >> 5);
         chk("chain_b0_side", {beats[0].keep, beats[0].otype, 3'b0, beats[0].last}, {16'hFFFF, 4'd3, 4'd0});
         chk("chain_b1_side", {beats[1].keep, beats[1].otype, 3'b0, beats[1].last}, {16'hFFFF, 4'd3, 4'd1});
         chk("chain_b1_data", beats[1].data, pay(201));
         chk("chain_b2_side", {beats[2].keep, beats[2].otype, 3'b0, beats[2].last}, {16'hFFFF, 4'd1, 4'd1});
         chk("chain_b2_data", beats[2].data, pay(202));
      end

      // Truncated sized OBU with a toggling downstream ready.
      clear_obs();
      toggle_ready = 1'b1;
      send({8'h32, 8'h40, 112'h0}, 16'hFFFF, 1'b0);
      send(pay(210), 16'hFFFF, 1'b0);
      send(pay(211), 16'hFFFF, 1'b1);
      drain_and_clear_start();
      toggle_ready = 1'b0;
      exp_obu++;
      exp_errs++;
      chk("trunc_beats", 128'(beats.size()), 128'd2);
      chk("trunc_err_pulses", 128'(ep_seen), 128'd1);
      chk("trunc_err_count", 128'(err_count), 128'(exp_errs));
      if (beats.size() == 2) begin
         chk("trunc_b0", {beats[0].keep, beats[0].otype, 3'b0, beats[0].last}, {16'hFFFF, 4'd6, 4'd0});
         chk("trunc_b0_data", beats[0].data, pay(210));
         chk("trunc_b1", {beats[1].keep, beats[1].otype, 3'b0, beats[1].last}, {16'hFFFF, 4'd6, 4'd1});
         chk("trunc_b1_data", beats[1].data, pay(211));
      end

      // Reset in the middle of an OBU while the output register is stalled.
      clear_obs();
      toggle_ready = 1'b1;
      @(posedge clk);
      #1;
      toggle_ready = 1'b0;
      @(posedge clk);
      send({8'h32, 8'h40, 112'h0}, 16'hFFFF, 1'b0);
      send(pay(220), 16'hFFFF, 1'b0);
      #1;
      rst = 1'b1;
      #2;
      chk("midrst_m_valid", 128'(m_axis_tvalid), 128'd0);
      chk("midrst_obu_count", 128'(obu_count), 128'd0);
      chk("midrst_err_count", 128'(err_count), 128'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_obs();
      send({8'h0A, 8'h10, 112'h0}, 16'hFFFF, 1'b0);
      send(pay(230), 16'hFFFF, 1'b0);
      drain_and_clear_start();
      chk("postrst_beats", 128'(beats.size()), 128'd1);
      chk("postrst_obu_count", 128'(obu_count), 128'd1);
      chk("postrst_hdr", {hdr_type, hdr_size}, {4'd1, 8'd16});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, required finish before 200000 ns");
      $fatal(1, "timeout");
   end

endmodule
